// File: rtl/kiwi_cfg_regs_pkg.sv
// Shared constants and helpers for the Kiwi AXI4-Lite config/status block.
// Response codes, word map and byte-strobe merge.
package kiwi_cfg_regs_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Config word map
  localparam int CTRL     = 0;
  localparam int RX_FREQ0 = 1;
  localparam int RX_FREQ1 = 2;
  localparam int RX_FREQ2 = 3;
  localparam int RX_FREQ3 = 4;
  localparam int RX_FREQ4 = 5;
  localparam int RX_FREQ5 = 6;
  localparam int RX_FREQ6 = 7;
  localparam int RX_FREQ7 = 8;
  localparam int WF_FREQ0 = 9;
  localparam int WF_DEC0  = 10;
  localparam int WF_FREQ1 = 11;
  localparam int WF_DEC1  = 12;
  localparam int WF_FREQ2 = 13;
  localparam int WF_DEC2  = 14;
  localparam int WF_FREQ3 = 15;
  localparam int WF_DEC3  = 16;
  localparam int GEN_FREQ = 17;

  // Status word map
  localparam int STS_RX_CNT  = 0;
  localparam int STS_WF_CNT0 = 1;
  localparam int STS_WF_CNT1 = 2;
  localparam int STS_WF_CNT2 = 3;
  localparam int STS_WF_CNT3 = 4;

  function automatic logic [31:0] apply_strb(
    input logic [31:0] old_word,
    input logic [31:0] new_word,
    input logic [3:0]  strb
  );
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/kiwi_cfg_wr_chan.sv
// AXI4-Lite write side: independent AW/W holding registers and B response.
// Presents one commit strobe per write to the register file.
module kiwi_cfg_wr_chan
  import kiwi_cfg_regs_pkg::*;
#(
  parameter int CFG_WORDS  = 18,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [31:0]           s_axi_wdata,
  input  logic [3:0]            s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  output logic                  commit,
  output logic                  commit_ok,
  output logic [ADDR_WIDTH-4:0] commit_idx,
  output logic [31:0]           commit_data,
  output logic [3:0]            commit_strb
);

  logic                  aw_held;
  logic                  w_held;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [31:0]           w_data;
  logic [3:0]            w_strb;
  logic                  unused_lsb;

  assign unused_lsb = ^aw_addr[1:0];

  assign s_axi_awready = !aw_held && !s_axi_bvalid;
  assign s_axi_wready  = !w_held && !s_axi_bvalid;

  assign commit      = aw_held && w_held;
  assign commit_idx  = aw_addr[ADDR_WIDTH-2:2];
  assign commit_data = w_data;
  assign commit_strb = w_strb;
  assign commit_ok   = !aw_addr[ADDR_WIDTH-1]
                    && (int'(commit_idx) < CFG_WORDS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      aw_addr      <= '0;
      w_data       <= '0;
      w_strb       <= '0;
      s_axi_bvalid <= 1'b0;
      s_axi_bresp  <= RESP_OKAY;
    end else begin
      if (s_axi_awvalid && s_axi_awready) begin
        aw_held <= 1'b1;
        aw_addr <= s_axi_awaddr;
      end
      if (s_axi_wvalid && s_axi_wready) begin
        w_held <= 1'b1;
        w_data <= s_axi_wdata;
        w_strb <= s_axi_wstrb;
      end
      // Holds can only be full while bvalid is low, so no overlap here
      if (commit) begin
        aw_held      <= 1'b0;
        w_held       <= 1'b0;
        s_axi_bvalid <= 1'b1;
        s_axi_bresp  <= commit_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (s_axi_bvalid && s_axi_bready) begin
        s_axi_bvalid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/kiwi_cfg_regs.sv
// Kiwi config/status register file behind an AXI4-Lite slave.
// Upper address bit splits R/W config words from read-only status words.
module kiwi_cfg_regs
  import kiwi_cfg_regs_pkg::*;
#(
  parameter int CFG_WORDS  = 18,
  parameter int STS_WORDS  = 5,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [31:0]             s_axi_wdata,
  input  logic [3:0]              s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [31:0]             s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic [CFG_WORDS*32-1:0] cfg_data,
  output logic [CFG_WORDS-1:0]    cfg_wr,
  input  logic [STS_WORDS*32-1:0] sts_data
);

  logic [31:0]           cfg_q [CFG_WORDS];
  logic                  commit;
  logic                  commit_ok;
  logic [ADDR_WIDTH-4:0] commit_idx;
  logic [31:0]           commit_data;
  logic [3:0]            commit_strb;

  kiwi_cfg_wr_chan #(
    .CFG_WORDS  (CFG_WORDS),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_wr_chan (
    .clk           (aclk),
    .rst           (areset),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .commit        (commit),
    .commit_ok     (commit_ok),
    .commit_idx    (commit_idx),
    .commit_data   (commit_data),
    .commit_strb   (commit_strb)
  );

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int n = 0; n < CFG_WORDS; n++) cfg_q[n] <= '0;
      cfg_wr <= '0;
    end else begin
      cfg_wr <= '0;
      if (commit && commit_ok) begin
        for (int n = 0; n < CFG_WORDS; n++) begin
          if (int'(commit_idx) == n) begin
            cfg_q[n]  <= apply_strb(cfg_q[n], commit_data, commit_strb);
            cfg_wr[n] <= 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    cfg_data = '0;
    for (int n = 0; n < CFG_WORDS; n++) cfg_data[32*n +: 32] = cfg_q[n];
  end

  logic [ADDR_WIDTH-4:0] rd_idx;
  logic                  rd_sts;
  logic [31:0]           rd_word;
  logic                  rd_ok;
  logic                  unused_rd_lsb;

  assign rd_idx        = s_axi_araddr[ADDR_WIDTH-2:2];
  assign rd_sts        = s_axi_araddr[ADDR_WIDTH-1];
  assign unused_rd_lsb = ^s_axi_araddr[1:0];
  assign s_axi_arready = !s_axi_rvalid;

  always_comb begin
    rd_word = '0;
    rd_ok   = 1'b0;
    for (int n = 0; n < CFG_WORDS; n++) begin
      if (!rd_sts && int'(rd_idx) == n) begin
        rd_word = cfg_q[n];
        rd_ok   = 1'b1;
      end
    end
    for (int n = 0; n < STS_WORDS; n++) begin
      if (rd_sts && int'(rd_idx) == n) begin
        rd_word = sts_data[32*n +: 32];
        rd_ok   = 1'b1;
      end
    end
  end

  // cfg_q is sampled pre-update, so a same-edge commit is not visible
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      s_axi_rvalid <= 1'b0;
      s_axi_rdata  <= '0;
      s_axi_rresp  <= RESP_OKAY;
    end else if (s_axi_arvalid && s_axi_arready) begin
      s_axi_rvalid <= 1'b1;
      s_axi_rdata  <= rd_word;
      s_axi_rresp  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (s_axi_rvalid && s_axi_rready) begin
      s_axi_rvalid <= 1'b0;
    end
  end

endmodule
